pkt_rd_ctrl: RTL and testbench

- Read-side controller for the single-packet RAM buffer; sits directly downstream of the write-side controller.
- Once the writer reports a complete packet stored (busy high), it reads the words back from RAM and emits them as a val/sop/eop stream with ready backpressure.
- After the last word is accepted, it pulses clear back to the writer, which releases the buffer for the next packet.

---
 rtl/pkt_rd_ctrl.sv | 126 ++++++++++++
 tb/tb_pkt_rd_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pkt_rd_ctrl.sv
// Read-side controller for the single-packet RAM buffer: streams a stored packet out as val/sop/eop.
// Optional build macro PKT_RD_REVERSE_EN reads the RAM in descending address order.
module pkt_rd_ctrl #(
   parameter int AWIDTH = 4,
   parameter int DWIDTH = 8
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic              busy_i,
   input  logic [AWIDTH-1:0] wrlen_i,
   output logic              rden_o,
   output logic [AWIDTH-1:0] rdaddr_o,
   input  logic [DWIDTH-1:0] rddata_i,
   output logic [DWIDTH-1:0] data_o,
   output logic              val_o,
   output logic              sop_o,
   output logic              eop_o,
   input  logic              ready_i,
   output logic              clr_o,
   output logic [1:0]        state_o
);

   // Handshake: a word transfers on any clock edge where val_o && ready_i; while val_o is high
   // and ready_i is low, data_o/sop_o/eop_o hold their values.
   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_CLR} state_t;

   localparam int CW = AWIDTH + 1;
   localparam logic [CW-1:0] FULL_LEN = CW'(1) << AWIDTH;

   state_t            state, state_nxt;
   logic [CW-1:0]     len, rd_cnt, out_cnt;
   logic              rd_pend;
   logic [DWIDTH-1:0] fifo_mem [4];
   logic [1:0]        wr_ptr, rd_ptr;
   logic [2:0]        fifo_cnt;
   logic              credit, push, pop, start;
   logic [AWIDTH-1:0] addr_cur, addr_last;

   // A read in flight still needs a FIFO slot when its data returns next cycle.
   assign credit = (fifo_cnt + 3'(rd_pend)) < 3'd4;
   assign push   = rd_pend;
   assign pop    = val_o & ready_i;
   assign start  = (state == S_IDLE) && busy_i;

`ifdef PKT_RD_REVERSE_EN
   logic [CW-1:0] addr_full;
   assign addr_full = len - CW'(1) - rd_cnt;
   assign addr_cur  = addr_full[AWIDTH-1:0];
`else
   assign addr_cur  = rd_cnt[AWIDTH-1:0];
`endif

   assign rdaddr_o = rden_o ? addr_cur : addr_last;
   assign val_o    = (fifo_cnt != 3'd0);
   assign data_o   = val_o ? fifo_mem[rd_ptr] : '0;
   assign sop_o    = val_o && (out_cnt == '0);
   assign eop_o    = val_o && (out_cnt == len - CW'(1));
   assign state_o  = state;

   always_comb begin
      state_nxt = state;
      rden_o    = 1'b0;
      clr_o     = 1'b0;
      case (state)
         S_IDLE:  if (busy_i) state_nxt = S_READ;
         S_READ: begin
            if (credit) begin
               rden_o = 1'b1;
               if (rd_cnt + CW'(1) == len) state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: if (pop && eop_o) state_nxt = S_CLR;
         S_CLR: begin
            clr_o     = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge srst_i) begin
      if (srst_i) begin
         state     <= S_IDLE;
         len       <= '0;
         rd_cnt    <= '0;
         out_cnt   <= '0;
         rd_pend   <= 1'b0;
         addr_last <= '0;
      end else begin
         state   <= state_nxt;
         rd_pend <= rden_o;
         if (start) begin
            len     <= (wrlen_i == '0) ? FULL_LEN : {1'b0, wrlen_i};
            rd_cnt  <= '0;
            out_cnt <= '0;
         end else begin
            if (rden_o) begin
               rd_cnt    <= rd_cnt + CW'(1);
               addr_last <= addr_cur;
            end
            if (pop) out_cnt <= out_cnt + CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge srst_i) begin
      if (srst_i) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 2'd1;
         if (pop)  rd_ptr <= rd_ptr + 2'd1;
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
            2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) fifo_mem[wr_ptr] <= rddata_i;
   end

endmodule

// File: tb/tb_pkt_rd_ctrl.sv
// Directed bench for pkt_rd_ctrl: table of packets plus reset-abort sequence, with a behavioural RAM.
module tb_pkt_rd_ctrl;

   logic       clk = 1'b0;
   logic       srst_i;
   logic       busy_i;
   logic [3:0] wrlen_i;
   logic       rden_o;
   logic [3:0] rdaddr_o;
   logic [7:0] rddata_i;
   logic [7:0] data_o;
   logic       val_o, sop_o, eop_o;
   logic       ready_i;
   logic       clr_o;
   logic [1:0] state_o;

   int tests = 0;
   int fails = 0;
   logic [7:0] ram [16];

   always #5 clk = ~clk;

   always @(posedge clk) if (rden_o) rddata_i <= ram[rdaddr_o];

   pkt_rd_ctrl #(.AWIDTH(4), .DWIDTH(8)) dut (
      .clk_i(clk), .srst_i(srst_i), .busy_i(busy_i), .wrlen_i(wrlen_i),
      .rden_o(rden_o), .rdaddr_o(rdaddr_o), .rddata_i(rddata_i),
      .data_o(data_o), .val_o(val_o), .sop_o(sop_o), .eop_o(eop_o),
      .ready_i(ready_i), .clr_o(clr_o), .state_o(state_o)
   );

   typedef struct {
      logic [3:0] wl;
      logic [7:0] base;
      int         stall_at;
      int         stall_n;
      int         exp_len;
      logic [7:0] exp_first;
      logic [7:0] exp_last;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] exp_word(input logic [7:0] base, input int len, input int idx);
`ifdef PKT_RD_REVERSE_EN
      return base + 8'(len - 1 - idx);
`else
      return base + 8'(idx);
`endif
   endfunction

   function automatic logic [3:0] exp_addr(input int len, input int k);
`ifdef PKT_RD_REVERSE_EN
      return 4'(len - 1 - k);
`else
      return 4'(k);
`endif
   endfunction

   // Watches one packet from the cycle after busy_i is seen in IDLE through clr_o.
   task automatic monitor_pkt(input vec_t v);
      int len, cyc, acc, issued, first_rd, first_val, eop_cyc, clr_cnt, stalled;
      logic [7:0] h_data;
      logic h_sop, h_eop;
      logic [7:0] ef, el;
      len = (v.wl == 0) ? 16 : int'(v.wl);
      cyc = 0; acc = 0; issued = 0; first_rd = -1; first_val = -1;
      eop_cyc = -1; clr_cnt = 0; stalled = 0;
      h_data = 0; h_sop = 0; h_eop = 0;
`ifdef PKT_RD_REVERSE_EN
      ef = v.exp_last; el = v.exp_first;
`else
      ef = v.exp_first; el = v.exp_last;
`endif
      while (clr_cnt == 0 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (v.stall_n > 0 && acc == v.stall_at && stalled < v.stall_n) begin
            ready_i = 1'b0;
            stalled++;
         end else ready_i = 1'b1;
         #1;
         if (rden_o) begin
            chk("rdaddr", rdaddr_o, exp_addr(len, issued));
            issued++;
            if (first_rd < 0) first_rd = cyc;
         end
         chk("inflight_bound", (issued - acc <= 4), 1);
         if (!ready_i && val_o) begin
            if (stalled == 1) begin
               h_data = data_o; h_sop = sop_o; h_eop = eop_o;
            end else begin
               chk("stall_data", data_o, h_data);
               chk("stall_sop", sop_o, h_sop);
               chk("stall_eop", eop_o, h_eop);
            end
         end
         if (val_o && ready_i) begin
            chk("data", data_o, exp_word(v.base, len, acc));
            chk("sop", sop_o, acc == 0);
            chk("eop", eop_o, acc == len - 1);
            if (acc == 0) chk("first_word", data_o, ef);
            if (acc == len - 1) begin
               chk("last_word", data_o, el);
               eop_cyc = cyc;
            end
            if (first_val < 0) first_val = cyc;
            acc++;
         end
         if (clr_o) begin
            clr_cnt++;
            chk("clr_timing", cyc, eop_cyc + 1);
            busy_i = 1'b0;
         end
      end
      chk("clr_seen", clr_cnt, 1);
      chk("accepted", acc, v.exp_len);
      chk("reads_issued", issued, v.exp_len);
      chk("first_rden_lat", first_rd, 1);
      chk("first_val_lat", first_val, first_rd + 2);
      if (v.stall_n == 0) chk("throughput", eop_cyc - first_val, len - 1);
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         #1;
         chk("tail_rden", rden_o, 0);
         chk("tail_val", val_o, 0);
         chk("tail_clr", clr_o, 0);
      end
   endtask

   task automatic run_pkt(input vec_t v);
      for (int i = 0; i < 16; i++) ram[i] = v.base + 8'(i);
      @(negedge clk);
      wrlen_i = v.wl;
      busy_i  = 1'b1;
      ready_i = 1'b1;
      monitor_pkt(v);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_rden"}, rden_o, 0);
      chk({tag, "_rdaddr"}, rdaddr_o, 0);
      chk({tag, "_data"}, data_o, 0);
      chk({tag, "_val"}, val_o, 0);
      chk({tag, "_sop"}, sop_o, 0);
      chk({tag, "_eop"}, eop_o, 0);
      chk({tag, "_clr"}, clr_o, 0);
      chk({tag, "_state"}, state_o, 0);
   endtask

   initial begin
      vec_t av;
      vecs[0] = '{4'd5, 8'h10, 0, 0, 5,  8'h10, 8'h14};
      vecs[1] = '{4'd1, 8'h20, 0, 0, 1,  8'h20, 8'h20};
      vecs[2] = '{4'd0, 8'h30, 0, 0, 16, 8'h30, 8'h3F};
      vecs[3] = '{4'd8, 8'h50, 3, 6, 8,  8'h50, 8'h57};
      vecs[4] = '{4'd3, 8'h60, 0, 0, 3,  8'h60, 8'h62};
      vecs[5] = '{4'd7, 8'h70, 0, 0, 7,  8'h70, 8'h76};

      srst_i = 1'b1; busy_i = 1'b0; wrlen_i = 4'd0; ready_i = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk_all_zero("reset");
      @(negedge clk);
      srst_i = 1'b0;

      for (int n = 0; n < 6; n++) run_pkt(vecs[n]);

      // Reset during READ of an 8-word packet, then replay with busy_i still high.
      av = '{4'd8, 8'hA0, 0, 0, 8, 8'hA0, 8'hA7};
      for (int i = 0; i < 16; i++) ram[i] = av.base + 8'(i);
      @(negedge clk);
      wrlen_i = av.wl; busy_i = 1'b1; ready_i = 1'b1;
      repeat (3) @(negedge clk);
      srst_i = 1'b1;
      #1;
      chk_all_zero("abort");
      repeat (2) begin
         @(negedge clk);
         #1;
         chk("abort_hold_clr", clr_o, 0);
         chk("abort_hold_val", val_o, 0);
      end
      srst_i = 1'b0;
      monitor_pkt(av);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
